// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : frame layout and host state encoding shared with the SPI slave
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int TURN_DEF   = 2;
    localparam int FRAME      = ADDR_W_DEF + 1 + TURN_DEF + DATA_W_DEF;
    localparam int ADDR_OFS   = 0;
    localparam int CMD_OFS    = ADDR_OFS + ADDR_W_DEF;
    localparam int DATA_OFS   = CMD_OFS + 1 + TURN_DEF;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_CMD   = 3'd3,
        ST_TURN  = 3'd4,
        ST_DATA  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_shifter.sv
// ============================================================================
// spi_shifter : parallel-load / serial-out and serial-in / parallel-out word
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module spi_shifter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              capture,
    input  logic              sin,
    output logic              sout,
    output logic [DATA_W-1:0] data_next
);

    logic [DATA_W-1:0] data_q;

    // One shift path serves both directions; capture selects what enters the LSB.
    always_comb begin
        data_next = data_q;
        if (load) begin
            data_next = load_data;
        end else if (shift || capture) begin
            data_next = {data_q[DATA_W-2:0], capture ? sin : 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_next;
        end
    end

    assign sout = data_q[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/spi_host.sv
// ============================================================================
// spi_host : serialises register read/write requests into fixed SPI frames
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module spi_host
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TURN   = TURN_DEF,
    parameter int RD_LAG = 1,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sdo,
    input  logic              sdi,
    output logic              busy
);

    localparam int FRAME_LEN = ADDR_W + 1 + TURN + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + GAP + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FRAME_LEN + GAP - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [ADDR_W-1:0]   addr_sh;
    logic                wr;
    logic                sdo_next;
    logic                accept;
    logic                frame_done;
    logic                shift_en;
    logic                cap_en;
    logic                in_read_data;
    logic                sh_sout;
    logic [DATA_W-1:0]   sh_next;

    assign accept       = (state == ST_IDLE) && req_valid;
    assign in_read_data = (state == ST_DATA) && !wr;
    assign shift_en     = (state_next == ST_DATA) && wr;
    assign frame_done   = (state != ST_IDLE) && (state != ST_FLUSH) && (state_next == ST_IDLE);
    assign req_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_FLUSH: if (cnt == FLUSH_LAST) state_next = ST_IDLE;
            ST_IDLE:  if (req_valid) state_next = ST_ADDR;
            ST_ADDR:  if (cnt == ADDR_LAST) state_next = ST_CMD;
            ST_CMD:   state_next = (TURN > 0) ? ST_TURN : ST_DATA;
            ST_TURN:  if (cnt == TURN_LAST) state_next = ST_DATA;
            ST_DATA:  if (cnt == DATA_LAST) state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (cnt == GAP_LAST) state_next = ST_IDLE;
            default:  state_next = ST_FLUSH;
        endcase
    end

    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if ((state_next != state) || (state == ST_IDLE)) begin
            cnt_next = '0;
        end
    end

    // sdo is registered, so it is loaded with the bit belonging to the next cycle.
    always_comb begin
        sdo_next = 1'b0;
        case (state_next)
            ST_ADDR: sdo_next = accept ? req_addr[ADDR_W-1] : addr_sh[ADDR_W-1];
            ST_CMD:  sdo_next = wr;
            ST_DATA: sdo_next = wr & sh_sout;
            default: sdo_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FLUSH;
            cnt       <= '0;
            sdo       <= 1'b0;
            addr_sh   <= '0;
            wr        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sdo       <= sdo_next;
            rsp_valid <= frame_done && !wr;
            if (accept) begin
                addr_sh <= req_addr << 1;
                wr      <= req_write;
            end else if (state == ST_ADDR) begin
                addr_sh <= addr_sh << 1;
            end
            if (frame_done && !wr) begin
                rsp_rdata <= sh_next;
            end
        end
    end

    // The slave answers RD_LAG cycles late, so the capture window trails DATA.
    if (RD_LAG == 0) begin : g_lag_none
        assign cap_en = in_read_data;
    end else begin : g_lag_line
        logic [RD_LAG-1:0] line;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line <= '0;
            end else begin
                line <= (line << 1) | RD_LAG'(in_read_data);
            end
        end
        assign cap_en = line[RD_LAG-1];
    end

    spi_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (req_wdata),
        .shift     (shift_en),
        .capture   (cap_en),
        .sin       (sdi),
        .sout      (sh_sout),
        .data_next (sh_next)
    );

endmodule

`default_nettype wire

// File: tb/tb_spi_host.sv
// ============================================================================
// tb_spi_host : frame-level model plus directed vectors for three lag configs
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_spi_host;

    localparam int FRAME = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [4:0]  req_addr  [3];
    logic        req_write [3];
    logic [15:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic        sdo       [3];
    logic        sdi       [3];
    logic        busy      [3];
    logic [15:0] word      [3];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // instance 0: defaults; 1: RD_LAG=0; 2: RD_LAG=3, GAP=3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_host #(
            .RD_LAG ((g == 0) ? 1 : (g == 1) ? 0 : 3),
            .GAP    ((g == 2) ? 3 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_write (req_write[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .sdo       (sdo[g]),
            .sdi       (sdi[g]),
            .busy      (busy[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lag(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    function automatic int gap(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    // Model: phase 0 = flush, 1 = idle, 2 = in frame (mcnt = frame cycle).
    int          mph   [3];
    int          mcnt  [3];
    logic        mwr   [3];
    logic        mrsp  [3];
    logic [23:0] mbits [3];
    logic [15:0] mword [3];
    logic [15:0] mrdata[3];
    logic        esdo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mph[i]    <= 0;
                mcnt[i]   <= 0;
                mwr[i]    <= 1'b0;
                mrsp[i]   <= 1'b0;
                mbits[i]  <= '0;
                mword[i]  <= '0;
                mrdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                mrsp[i] <= 1'b0;
                if (mph[i] == 0) begin
                    if (mcnt[i] == FRAME + gap(i) - 1) begin
                        mph[i]  <= 1;
                        mcnt[i] <= 0;
                    end else begin
                        mcnt[i] <= mcnt[i] + 1;
                    end
                end else if (mph[i] == 1) begin
                    if (req_valid[i]) begin
                        mph[i]   <= 2;
                        mcnt[i]  <= 0;
                        mwr[i]   <= req_write[i];
                        mword[i] <= word[i];
                        mbits[i] <= {req_addr[i], req_write[i], 2'b00,
                                     req_write[i] ? req_wdata[i] : 16'h0000};
                    end
                end else begin
                    if (mcnt[i] == FRAME + gap(i) - 1) begin
                        mph[i] <= 1;
                        if (!mwr[i]) begin
                            mrsp[i]   <= 1'b1;
                            mrdata[i] <= mword[i];
                        end
                    end else begin
                        mcnt[i] <= mcnt[i] + 1;
                    end
                end
            end
        end
    end

    // Compare against the model, then drive the slave's reply for the coming edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cyc > 0) begin
                esdo = (mph[i] == 2 && mcnt[i] < FRAME) ? mbits[i][FRAME-1-mcnt[i]] : 1'b0;
                chk("sdo",       i, 32'(sdo[i]),       32'(esdo));
                chk("req_ready", i, 32'(req_ready[i]), 32'(mph[i] == 1));
                chk("busy",      i, 32'(busy[i]),      32'(mph[i] != 1));
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(mrsp[i]));
                chk("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(mrdata[i]));
            end
            if (mph[i] == 2 && !mwr[i] && mcnt[i] >= 8 + lag(i) && mcnt[i] < 24 + lag(i)) begin
                sdi[i] = mword[i][15 - (mcnt[i] - 8 - lag(i))];
            end else begin
                sdi[i] = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input int i, input logic [4:0] a, input logic w, input logic [15:0] d,
                        input logic [15:0] reply, input bit hold, output int acc, output int waited);
        req_addr[i]  = a;
        req_write[i] = w;
        req_wdata[i] = d;
        word[i]      = reply;
        req_valid[i] = 1'b1;
        waited = 0;
        while (req_ready[i] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_in_time", i, 32'(waited < 200), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input int exp_at, input logic [15:0] exp_d);
        int at;
        int bad;
        logic [15:0] got;
        at  = -1;
        bad = 0;
        got = '0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k >= 8 && k < 24 && sdo[i] !== 1'b0) bad++;
            if (rsp_valid[i] === 1'b1) begin
                at  = k;
                got = rsp_rdata[i];
                break;
            end
        end
        chk("rsp_cycle",     i, 32'(at),  32'(exp_at));
        chk("rsp_data",      i, 32'(got), 32'(exp_d));
        chk("read_sdo_zero", i, 32'(bad), 32'd0);
    endtask

    task automatic count_flush(input int i, output int n, output int ones, output int nrsp);
        n    = 0;
        ones = 0;
        nrsp = 0;
        while (req_ready[i] !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (rsp_valid[i] === 1'b1) nrsp++;
            if (req_ready[i] !== 1'b1) begin
                n++;
                if (sdo[i] !== 1'b0) ones++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc1, acc2, w, n, ones, nrsp;
        logic [23:0] shv;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_write[i] = 1'b0;
            req_wdata[i] = '0;
            word[i]      = '0;
            sdi[i]       = 1'b0;
        end

        // Reset flush
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        count_flush(0, n, ones, nrsp);
        chk("flush_len",     0, 32'(n),    32'd25);
        chk("flush_sdo_one", 0, 32'(ones), 32'd0);

        // Write frame
        send(0, 5'h13, 1'b1, 16'hA5C3, 16'h0000, 1'b0, acc1, w);
        shv  = '0;
        nrsp = 0;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            if (k < 24) shv = {shv[22:0], sdo[0]};
            if (rsp_valid[0] === 1'b1) nrsp++;
        end
        chk("write_frame",  0, 32'(shv),  32'h009CA5C3);
        chk("write_no_rsp", 0, 32'(nrsp), 32'd0);

        // Read frame
        send(0, 5'h02, 1'b0, 16'h0000, 16'h1234, 1'b0, acc1, w);
        wait_rsp(0, 25, 16'h1234);

        // Back-to-back with req_valid held across both requests
        send(0, 5'h11, 1'b1, 16'hFFFF, 16'h0000, 1'b1, acc1, w);
        send(0, 5'h0A, 1'b0, 16'h0000, 16'h5A0F, 1'b0, acc2, w);
        chk("b2b_period", 0, 32'(acc2 - acc1), 32'd26);
        chk("b2b_wait",   0, 32'(w),           32'd26);
        wait_rsp(0, 25, 16'h5A0F);

        // Mid-frame reset during a read
        send(0, 5'h07, 1'b0, 16'h0000, 16'hDEAD, 1'b0, acc1, w);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_sdo",   0, 32'(sdo[0]),       32'd0);
        chk("rst_ready", 0, 32'(req_ready[0]), 32'd0);
        chk("rst_busy",  0, 32'(busy[0]),      32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        count_flush(0, n, ones, nrsp);
        chk("reflush_len",    0, 32'(n),    32'd25);
        chk("reflush_no_rsp", 0, 32'(nrsp), 32'd0);
        chk("reflush_sdo",    0, 32'(ones), 32'd0);
        send(0, 5'h1C, 1'b0, 16'h0000, 16'hBEEF, 1'b0, acc1, w);
        wait_rsp(0, 25, 16'hBEEF);

        // Lag sweep
        send(1, 5'h03, 1'b0, 16'h0000, 16'hC0DE, 1'b0, acc1, w);
        wait_rsp(1, 25, 16'hC0DE);
        send(2, 5'h1F, 1'b0, 16'hFFFF, 16'h7E81, 1'b0, acc1, w);
        wait_rsp(2, 27, 16'h7E81);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
